// File: rtl/udp_tx_sched_if.sv
// Signal bundle between the two packetizers, the TX scheduler and the UDP transmit engine.
// The master modport is the scheduler's view; slave is the surrounding environment.
interface udp_tx_sched_if;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DATA_W = 32;

  logic              ch0_start_en;
  logic              ch1_start_en;
  logic [LEN_W-1:0]  ch0_byte_num;
  logic [LEN_W-1:0]  ch1_byte_num;
  logic [DATA_W-1:0] ch0_tx_data;
  logic [DATA_W-1:0] ch1_tx_data;
  logic              ch0_tx_req;
  logic              ch1_tx_req;
  logic              ch0_tx_done;
  logic              ch1_tx_done;
  logic              udp_tx_start_en;
  logic [LEN_W-1:0]  udp_tx_byte_num;
  logic [DATA_W-1:0] udp_tx_data;
  logic              udp_tx_req;
  logic              udp_tx_done;
  logic              grant;
  logic              err_pulse;
  logic [1:0]        err_code;

  modport master (
    input  ch0_start_en, ch1_start_en, ch0_byte_num, ch1_byte_num,
           ch0_tx_data, ch1_tx_data, udp_tx_req, udp_tx_done,
    output ch0_tx_req, ch1_tx_req, ch0_tx_done, ch1_tx_done,
           udp_tx_start_en, udp_tx_byte_num, udp_tx_data, grant, err_pulse, err_code
  );

  modport slave (
    output ch0_start_en, ch1_start_en, ch0_byte_num, ch1_byte_num,
           ch0_tx_data, ch1_tx_data, udp_tx_req, udp_tx_done,
    input  ch0_tx_req, ch1_tx_req, ch0_tx_done, ch1_tx_done,
           udp_tx_start_en, udp_tx_byte_num, udp_tx_data, grant, err_pulse, err_code
  );
endinterface

// File: rtl/udp_tx_sched.sv
// Two-channel round-robin scheduler in front of the UDP TX engine: length check,
// grant, data/strobe routing, inter-packet gap and a done watchdog.
module udp_tx_sched #(
  parameter logic [15:0] IFG_CYCLES     = 16'd800,
  parameter logic [15:0] MAX_BYTE_NUM   = 16'd1472,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
  input  logic           eth_tx_clk,
  input  logic           rst_n,
  udp_tx_sched_if.master bus
);
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_CH = 2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_OVR  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_GAP} state_e;

  state_e                        state_q, state_d;
  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [NUM_CH-1:0][LEN_W-1:0]  len_q, len_d;
  logic                          last_grant_q, last_grant_d;
  logic                          grant_q, grant_d;
  logic [LEN_W-1:0]              byte_num_q, byte_num_d;
  logic                          start_en_q, start_en_d;
  logic [NUM_CH-1:0]             tx_done_q, tx_done_d;
  logic [CNT_W-1:0]              wd_q, wd_d;
  logic [CNT_W-1:0]              gap_q, gap_d;
  logic                          err_pulse_q, err_pulse_d;
  logic [1:0]                    err_code_q, err_code_d;

  logic [NUM_CH-1:0]             req_start;
  logic [NUM_CH-1:0][LEN_W-1:0]  req_len;
  logic [1:0]                    err_lvl;
  logic                          sel;

  assign req_start = {bus.ch1_start_en, bus.ch0_start_en};
  assign req_len   = {bus.ch1_byte_num, bus.ch0_byte_num};

  // Next-state: FSM first (it may clear a pend bit), then the request latches so a new
  // request arriving in the clearing cycle is accepted.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    len_d        = len_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    byte_num_d   = byte_num_q;
    start_en_d   = 1'b0;
    tx_done_d    = '0;
    wd_d         = wd_q;
    gap_d        = gap_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_lvl      = ERR_NONE;
    sel          = last_grant_q;

    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          sel        = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
          grant_d    = sel;
          byte_num_d = len_q[sel];
          start_en_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (bus.udp_tx_done || (wd_q >= TIMEOUT_CYCLES - 16'd1)) begin
          pend_d[grant_q]    = 1'b0;
          tx_done_d[grant_q] = 1'b1;
          gap_d              = '0;
          state_d            = S_GAP;
          if (bus.udp_tx_done) last_grant_d = grant_q;
          else                 err_lvl      = ERR_TMO;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q >= IFG_CYCLES - 16'd1) state_d = S_IDLE;
        else if (gap_q != '1)            gap_d   = gap_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    for (int n = 0; n < int'(NUM_CH); n++) begin
      if (req_start[1'(n)]) begin
        if ((req_len[1'(n)] == '0) || (req_len[1'(n)] > MAX_BYTE_NUM)) begin
          if (err_lvl < ERR_LEN) err_lvl = ERR_LEN;
        end else if (pend_d[1'(n)]) begin
          if (err_lvl < ERR_OVR) err_lvl = ERR_OVR;
        end else begin
          pend_d[1'(n)] = 1'b1;
          len_d[1'(n)]  = req_len[1'(n)];
        end
      end
    end

    // Numeric code order equals priority, so the largest code raised this cycle wins.
    if (err_lvl != ERR_NONE) begin
      err_pulse_d = 1'b1;
      err_code_d  = err_lvl;
    end
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      len_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      byte_num_q   <= '0;
      start_en_q   <= 1'b0;
      tx_done_q    <= '0;
      wd_q         <= '0;
      gap_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      len_q        <= len_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      byte_num_q   <= byte_num_d;
      start_en_q   <= start_en_d;
      tx_done_q    <= tx_done_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
    end
  end

  // Data path is gated to XFER so it reads as zero while idle or in reset.
  assign bus.ch0_tx_req      = bus.udp_tx_req & (state_q == S_XFER) & ~grant_q;
  assign bus.ch1_tx_req      = bus.udp_tx_req & (state_q == S_XFER) &  grant_q;
  assign bus.udp_tx_data     = (state_q != S_XFER) ? '0 :
                               (grant_q ? bus.ch1_tx_data : bus.ch0_tx_data);
  assign bus.udp_tx_start_en = start_en_q;
  assign bus.udp_tx_byte_num = byte_num_q;
  assign bus.ch0_tx_done     = tx_done_q[0];
  assign bus.ch1_tx_done     = tx_done_q[1];
  assign bus.grant           = grant_q;
  assign bus.err_pulse       = err_pulse_q;
  assign bus.err_code        = err_code_q;
endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: table of single requests plus hand-written
// contention, overrun, same-cycle, timeout and reset sequences.
module tb_udp_tx_sched;
  localparam int unsigned IFG = 800;
  localparam int unsigned TMO = 4000;

  logic eth_tx_clk = 1'b0;
  logic rst_n;

  udp_tx_sched_if bus();

  udp_tx_sched dut (
    .eth_tx_clk (eth_tx_clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #5 eth_tx_clk = ~eth_tx_clk;

  int checks   = 0;
  int failures = 0;

  // Edge monitor: registered outputs seen here are the values of the cycle just ended.
  int          cyc       = 0;
  int          n_start   = 0;
  int          n_done0   = 0;
  int          n_done1   = 0;
  int          n_err     = 0;
  int          start_cyc = 0;
  int          err_cyc   = 0;
  logic [15:0] start_len = '0;
  logic        start_grant = 1'b0;
  logic [1:0]  err_seen  = '0;

  always @(posedge eth_tx_clk) begin
    cyc++;
    if (bus.udp_tx_start_en) begin
      n_start++;
      start_cyc   = cyc;
      start_len   = bus.udp_tx_byte_num;
      start_grant = bus.grant;
    end
    if (bus.ch0_tx_done) n_done0++;
    if (bus.ch1_tx_done) n_done1++;
    if (bus.err_pulse) begin
      n_err++;
      err_cyc  = cyc;
      err_seen = bus.err_code;
    end
  end

  task automatic tick();
    @(posedge eth_tx_clk);
    @(negedge eth_tx_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name, input int n0, input int budget);
    int k = 0;
    while (n_start == n0 && k < budget) begin
      tick();
      k++;
    end
    if (n_start == n0) begin
      checks++;
      failures++;
      $display("FAIL %s: no udp_tx_start_en within %0d cycles", name, budget);
    end
  endtask

  task automatic request(input logic ch, input logic [15:0] len);
    if (ch) begin
      bus.ch1_start_en = 1'b1;
      bus.ch1_byte_num = len;
    end else begin
      bus.ch0_start_en = 1'b1;
      bus.ch0_byte_num = len;
    end
    tick();
    bus.ch0_start_en = 1'b0;
    bus.ch1_start_en = 1'b0;
  endtask

  task automatic finish_pkt(input string name, input logic ch, output int d);
    bus.udp_tx_done = 1'b1;
    tick();
    d = cyc;
    bus.udp_tx_done = 1'b0;
    chk({name, " ch0_tx_done"}, 32'(bus.ch0_tx_done), 32'(ch == 1'b0));
    chk({name, " ch1_tx_done"}, 32'(bus.ch1_tx_done), 32'(ch == 1'b1));
    tick();
    chk({name, " done low"}, 32'(bus.ch0_tx_done | bus.ch1_tx_done), 32'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " start_en"},  32'(bus.udp_tx_start_en), 32'(0));
    chk({tag, " byte_num"},  32'(bus.udp_tx_byte_num), 32'(0));
    chk({tag, " tx_data"},   bus.udp_tx_data, 32'(0));
    chk({tag, " tx_req"},    32'({bus.ch1_tx_req, bus.ch0_tx_req}), 32'(0));
    chk({tag, " tx_done"},   32'({bus.ch1_tx_done, bus.ch0_tx_done}), 32'(0));
    chk({tag, " grant"},     32'(bus.grant), 32'(0));
    chk({tag, " err_pulse"}, 32'(bus.err_pulse), 32'(0));
    chk({tag, " err_code"},  32'(bus.err_code), 32'(0));
  endtask

  typedef struct {
    logic        ch;
    logic [15:0] len;
    logic        exp_start;
    logic        exp_grant;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n0, e0, d, dn, req_cyc;
    logic [31:0] exp_data;

    tbl[0] = '{1'b0, 16'd964,  1'b1, 1'b0, 2'b00};
    tbl[1] = '{1'b1, 16'd64,   1'b1, 1'b1, 2'b00};
    tbl[2] = '{1'b0, 16'd0,    1'b0, 1'b0, 2'b01};
    tbl[3] = '{1'b1, 16'd1500, 1'b0, 1'b0, 2'b01};
    tbl[4] = '{1'b0, 16'd1472, 1'b1, 1'b0, 2'b00};
    tbl[5] = '{1'b1, 16'd1473, 1'b0, 1'b0, 2'b01};
    tbl[6] = '{1'b1, 16'd1,    1'b1, 1'b1, 2'b00};

    rst_n            = 1'b0;
    bus.ch0_start_en = 1'b0;
    bus.ch1_start_en = 1'b0;
    bus.ch0_byte_num = '0;
    bus.ch1_byte_num = '0;
    bus.ch0_tx_data  = 32'hA5A5_0000;
    bus.ch1_tx_data  = 32'h5A5A_0000;
    bus.udp_tx_req   = 1'b0;
    bus.udp_tx_done  = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single requests from the table
    for (int i = 0; i < 7; i++) begin
      n0 = n_start;
      request(tbl[i].ch, tbl[i].len);
      req_cyc = cyc;
      chk($sformatf("v%0d err_pulse", i), 32'(bus.err_pulse), 32'(tbl[i].exp_err != 2'b00));
      if (tbl[i].exp_err != 2'b00)
        chk($sformatf("v%0d err_code", i), 32'(bus.err_code), 32'(tbl[i].exp_err));
      if (tbl[i].exp_start) begin
        wait_start($sformatf("v%0d start", i), n0, 10);
        chk($sformatf("v%0d latency", i), 32'(start_cyc - req_cyc), 32'(2));
        chk($sformatf("v%0d byte_num", i), 32'(start_len), 32'(tbl[i].len));
        chk($sformatf("v%0d grant", i), 32'(start_grant), 32'(tbl[i].exp_grant));
        bus.ch0_tx_data = 32'hA000_0000 + 32'(i);
        bus.ch1_tx_data = 32'hB000_0000 + 32'(i);
        bus.udp_tx_req  = 1'b1;
        #1;
        exp_data = tbl[i].exp_grant ? 32'hB000_0000 + 32'(i) : 32'hA000_0000 + 32'(i);
        chk($sformatf("v%0d tx_data", i), bus.udp_tx_data, exp_data);
        chk($sformatf("v%0d ch0_tx_req", i), 32'(bus.ch0_tx_req), 32'(!tbl[i].exp_grant));
        chk($sformatf("v%0d ch1_tx_req", i), 32'(bus.ch1_tx_req), 32'(tbl[i].exp_grant));
        bus.udp_tx_req = 1'b0;
        #1;
        chk($sformatf("v%0d req follows", i), 32'({bus.ch1_tx_req, bus.ch0_tx_req}), 32'(0));
        finish_pkt($sformatf("v%0d", i), tbl[i].exp_grant, d);
        repeat (IFG) tick();
      end else begin
        repeat (5) tick();
        chk($sformatf("v%0d no start", i), 32'(n_start - n0), 32'(0));
      end
    end

    // Tie with last_grant=1: ch0 first, ch1 exactly one gap later
    n0 = n_start;
    bus.ch0_byte_num = 16'd964; bus.ch0_start_en = 1'b1;
    bus.ch1_byte_num = 16'd64;  bus.ch1_start_en = 1'b1;
    tick();
    bus.ch0_start_en = 1'b0; bus.ch1_start_en = 1'b0;
    chk("tieA no err", 32'(bus.err_pulse), 32'(0));
    wait_start("tieA first", n0, 10);
    chk("tieA first grant", 32'(start_grant), 32'(0));
    chk("tieA first len", 32'(start_len), 32'(964));
    finish_pkt("tieA first", 1'b0, d);
    wait_start("tieA second", n0 + 1, int'(IFG) + 20);
    chk("tieA gap", 32'(start_cyc - d), 32'(IFG + 2));
    chk("tieA second grant", 32'(start_grant), 32'(1));
    chk("tieA second len", 32'(start_len), 32'(64));
    finish_pkt("tieA second", 1'b1, d);
    repeat (IFG) tick();

    // Lone ch0 packet so the next tie goes to ch1
    n0 = n_start;
    request(1'b0, 16'd200);
    wait_start("solo", n0, 10);
    finish_pkt("solo", 1'b0, d);
    repeat (IFG) tick();

    n0 = n_start;
    bus.ch0_byte_num = 16'd300; bus.ch0_start_en = 1'b1;
    bus.ch1_byte_num = 16'd400; bus.ch1_start_en = 1'b1;
    tick();
    bus.ch0_start_en = 1'b0; bus.ch1_start_en = 1'b0;
    wait_start("tieB first", n0, 10);
    chk("tieB first grant", 32'(start_grant), 32'(1));
    chk("tieB first len", 32'(start_len), 32'(400));
    finish_pkt("tieB first", 1'b1, d);
    wait_start("tieB second", n0 + 1, int'(IFG) + 20);
    chk("tieB second grant", 32'(start_grant), 32'(0));
    chk("tieB second len", 32'(start_len), 32'(300));
    finish_pkt("tieB second", 1'b0, d);
    repeat (IFG) tick();

    // Overrun on ch1 while in flight: original length kept, one done only
    n0 = n_start;
    request(1'b1, 16'd100);
    wait_start("ovr", n0, 10);
    chk("ovr len", 32'(start_len), 32'(100));
    e0 = n_err;
    dn = n_done1;
    request(1'b1, 16'd200);
    chk("ovr err_pulse", 32'(bus.err_pulse), 32'(1));
    chk("ovr err_code", 32'(bus.err_code), 32'(2'b10));
    finish_pkt("ovr", 1'b1, d);
    repeat (IFG + 20) tick();
    chk("ovr one start", 32'(n_start - n0), 32'(1));
    chk("ovr one done", 32'(n_done1 - dn), 32'(1));
    chk("ovr one err", 32'(n_err - e0), 32'(1));

    // New ch0 request in the same cycle its packet completes is accepted
    n0 = n_start;
    request(1'b0, 16'd50);
    wait_start("setwin", n0, 10);
    e0 = n_err;
    bus.udp_tx_done  = 1'b1;
    bus.ch0_byte_num = 16'd60;
    bus.ch0_start_en = 1'b1;
    tick();
    d = cyc;
    bus.udp_tx_done  = 1'b0;
    bus.ch0_start_en = 1'b0;
    chk("setwin done", 32'(bus.ch0_tx_done), 32'(1));
    chk("setwin no err", 32'(bus.err_pulse), 32'(0));
    wait_start("setwin restart", n0 + 1, int'(IFG) + 20);
    chk("setwin gap", 32'(start_cyc - d), 32'(IFG + 2));
    chk("setwin len", 32'(start_len), 32'(60));
    chk("setwin grant", 32'(start_grant), 32'(0));
    chk("setwin errs", 32'(n_err - e0), 32'(0));
    finish_pkt("setwin2", 1'b0, d);
    repeat (IFG) tick();

    // Watchdog: timeout collides with a bad-length request; timeout code wins
    n0 = n_start;
    request(1'b0, 16'd32);
    wait_start("tmo", n0, 10);
    dn = n_done0;
    e0 = n_err;
    repeat (TMO - 1) tick();
    chk("tmo not early", 32'(n_err - e0), 32'(0));
    bus.ch1_byte_num = 16'd0;
    bus.ch1_start_en = 1'b1;
    tick();
    bus.ch1_start_en = 1'b0;
    chk("tmo err_pulse", 32'(bus.err_pulse), 32'(1));
    chk("tmo err_code", 32'(bus.err_code), 32'(2'b11));
    chk("tmo ch0_tx_done", 32'(bus.ch0_tx_done), 32'(1));
    tick();
    chk("tmo err cycle", 32'(err_cyc - start_cyc), 32'(TMO + 1));
    chk("tmo err seen", 32'(err_seen), 32'(2'b11));
    chk("tmo one done", 32'(n_done0 - dn), 32'(1));
    chk("tmo one err", 32'(n_err - e0), 32'(1));
    repeat (IFG) tick();
    n0 = n_start;
    request(1'b1, 16'd128);
    wait_start("post tmo", n0, 10);
    chk("post tmo grant", 32'(start_grant), 32'(1));
    chk("post tmo len", 32'(start_len), 32'(128));
    finish_pkt("post tmo", 1'b1, d);
    repeat (IFG) tick();

    // Asynchronous reset mid-packet, with a ch1 request left pending
    n0 = n_start;
    request(1'b0, 16'd77);
    request(1'b1, 16'd88);
    wait_start("rst", n0, 10);
    bus.ch0_tx_data = 32'hDEAD_BEEF;
    bus.udp_tx_req  = 1'b1;
    #1;
    chk("rst pre req", 32'(bus.ch0_tx_req), 32'(1));
    chk("rst pre data", bus.udp_tx_data, 32'hDEAD_BEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    bus.udp_tx_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n0 = n_start;
    repeat (20) tick();
    chk("no stale start", 32'(n_start - n0), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
